// File: rtl/deosc_multi_pkg.sv
// Shared tick-clock constants and hold-time helpers for the deoscillator blocks.
package deosc_multi_pkg;

  localparam int unsigned CLK_HZ      = 1_000_000;
  localparam int unsigned DEOSC_T_IR  = 5000;
  localparam int unsigned DEOSC_T_KEY = 20000;

  // A hold time is usable when it is at least one cycle and fits in the counter.
  function automatic bit time_ok(input int unsigned t, input int unsigned bits);
    if (t < 32'd1) return 1'b0;
    if (bits >= 32'd32) return 1'b1;
    return t <= ((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/deosc_chan.sv
// One deoscillator channel: two-flop synchroniser, hold counter and edge pulses.
module deosc_chan
  import deosc_multi_pkg::*;
#(
  parameter int unsigned BITS      = 13,
  parameter int unsigned TIME_RISE = DEOSC_T_IR,
  parameter int unsigned TIME_FALL = DEOSC_T_IR,
  parameter bit          INIT      = 1'b0
) (
  input  logic clkus,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [BITS-1:0] RISE_LAST = BITS'(TIME_RISE - 32'd1);
  localparam logic [BITS-1:0] FALL_LAST = BITS'(TIME_FALL - 32'd1);

  logic            sync1;
  logic            sync2;
  logic [BITS-1:0] cnt;
  logic [BITS-1:0] last_c;

  // Terminal count depends on the direction the synchronised input is heading.
  assign last_c = sync2 ? RISE_LAST : FALL_LAST;

  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INIT;
      sync2 <= INIT;
      out   <= INIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == out) begin
        cnt <= '0;
      end else if (cnt == last_c) begin
        out  <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + BITS'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/deosc_multi.sv
// Multi-channel glitch filter for IR receiver and push-button pins on the 1 MHz tick clock.
module deosc_multi
  import deosc_multi_pkg::*;
#(
  parameter int unsigned CH        = 4,
  parameter int unsigned BITS      = 13,
  parameter int unsigned TIME_RISE = DEOSC_T_IR,
  parameter int unsigned TIME_FALL = DEOSC_T_IR,
  parameter bit          INIT      = 1'b0
) (
  input  logic          clkus,
  input  logic          rst_n,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] busy
);

  // Hold times outside 1..2^BITS-1 would make the counter wrap or never fire.
  if (!time_ok(TIME_RISE, BITS) || !time_ok(TIME_FALL, BITS)) begin : g_param_err
    $error("deosc_multi: TIME_RISE/TIME_FALL must be in 1..2^BITS-1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    deosc_chan #(
      .BITS      (BITS),
      .TIME_RISE (TIME_RISE),
      .TIME_FALL (TIME_FALL),
      .INIT      (INIT)
    ) u_chan (
      .clkus (clkus),
      .rst_n (rst_n),
      .in    (in[i]),
      .out   (out[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .busy  (busy[i])
    );
  end

endmodule

// File: tb/tb_deosc_multi.sv
// Directed bench for deosc_multi: INIT=0 and INIT=1 builds checked against a window model.
module tb_deosc_multi;

  localparam int unsigned CH   = 2;
  localparam int unsigned BITS = 4;
  localparam int unsigned TR   = 4;
  localparam int unsigned TF   = 6;
  localparam int unsigned HD   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in_a, in_b;
  logic [CH-1:0] out_a, rise_a, fall_a, busy_a;
  logic [CH-1:0] out_b, rise_b, fall_b, busy_b;

  always #5 clk = ~clk;

  deosc_multi #(.CH(CH), .BITS(BITS), .TIME_RISE(TR), .TIME_FALL(TF), .INIT(1'b0)) dut_a (
    .clkus(clk), .rst_n(rst_n), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  deosc_multi #(.CH(CH), .BITS(BITS), .TIME_RISE(TR), .TIME_FALL(TF), .INIT(1'b1)) dut_b (
    .clkus(clk), .rst_n(rst_n), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: out flips to v once the last T synchronised samples (pin delayed by 2) all equal v.
  logic          hist [2][CH][HD];
  logic [CH-1:0] m_out  [2];
  logic [CH-1:0] m_rise [2];
  logic [CH-1:0] m_fall [2];
  logic [CH-1:0] m_busy [2];

  always @(posedge clk or negedge rst_n) begin : model
    logic v;
    int   t;
    bit   flip;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < CH; c++) begin
          for (int d = 0; d < HD; d++) hist[k][c][d] = (k == 1);
          m_out[k][c]  = (k == 1);
          m_rise[k][c] = 1'b0;
          m_fall[k][c] = 1'b0;
          m_busy[k][c] = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < CH; c++) begin
          v    = hist[k][c][1];
          t    = v ? int'(TR) : int'(TF);
          flip = (v != m_out[k][c]);
          for (int d = 1; d <= t; d++) if (hist[k][c][d] != v) flip = 1'b0;
          m_rise[k][c] = flip && v;
          m_fall[k][c] = flip && !v;
          if (flip) m_out[k][c] = v;
          m_busy[k][c] = (v != m_out[k][c]);
          for (int d = HD - 1; d > 0; d--) hist[k][c][d] = hist[k][c][d-1];
          hist[k][c][0] = (k == 1) ? in_b[c] : in_a[c];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("out_a",  out_a,  m_out[0]);
    chk("rise_a", rise_a, m_rise[0]);
    chk("fall_a", fall_a, m_fall[0]);
    chk("busy_a", busy_a, m_busy[0]);
    chk("out_b",  out_b,  m_out[1]);
    chk("rise_b", rise_b, m_rise[1]);
    chk("fall_b", fall_b, m_fall[1]);
    chk("busy_b", busy_b, m_busy[1]);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    in_a  = 2'b00;
    in_b  = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_a", out_a, 2'b00);
    chk("rst_out_b", out_b, 2'b11);
    chk("rst_busy_a", busy_a, 2'b00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_out_a", out_a, 2'b00);
    chk("idle_fall_b", fall_b, 2'b00);

    // Short pulse, then a bouncing train: neither may reach out.
    in_a = 2'b01; repeat (3) @(negedge clk);
    in_a = 2'b00; repeat (12) @(negedge clk);
    chk("glitch_out_a", out_a, 2'b00);
    chk("glitch_busy_a", busy_a, 2'b00);
    in_a = 2'b01; repeat (3) @(negedge clk);
    in_a = 2'b00; repeat (1) @(negedge clk);
    in_a = 2'b01; repeat (3) @(negedge clk);
    in_a = 2'b00; repeat (12) @(negedge clk);
    chk("train_out_a", out_a, 2'b00);

    // Held rise on channel 0.
    in_a = 2'b01;
    edges(2); chk("rise_busy_pre", busy_a, 2'b00);
    edges(1); chk("rise_busy_on", busy_a, 2'b01);
    edges(2); chk("rise_out_pre", out_a, 2'b00);
    edges(1); chk("rise_out", out_a, 2'b01);
    chk("rise_pulse", rise_a, 2'b01);
    chk("model_pin_rise", m_out[0], 2'b01);
    edges(1); chk("rise_pulse_end", rise_a, 2'b00);
    chk("rise_busy_end", busy_a, 2'b00);

    // Channel 0 falls while channel 1 rises two cycles later; both land on the same edge.
    @(negedge clk); in_a = 2'b00;
    @(negedge clk);
    @(negedge clk); in_a = 2'b10;
    edges(5); chk("mix_out_pre", out_a, 2'b01);
    edges(1); chk("mix_out", out_a, 2'b10);
    chk("mix_fall", fall_a, 2'b01);
    chk("mix_rise", rise_a, 2'b10);
    edges(1); chk("mix_pulse_end", fall_a | rise_a, 2'b00);

    // Reset mid-count on channel 1 discards the pending rise.
    @(negedge clk); in_a = 2'b00;
    repeat (12) @(negedge clk);
    chk("pre_rst_out_a", out_a, 2'b00);
    in_a = 2'b10;
    edges(4); chk("busy_before_rst", busy_a, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out_a, 2'b00);
    chk("async_rst_busy", busy_a, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    edges(5); chk("post_rst_out_pre", out_a, 2'b00);
    edges(1); chk("post_rst_out", out_a, 2'b10);
    chk("post_rst_rise", rise_a, 2'b10);

    // INIT=1 build: both channels fall on the same edge.
    @(negedge clk); in_b = 2'b00;
    edges(7); chk("initb_out_pre", out_b, 2'b11);
    edges(1); chk("initb_out", out_b, 2'b00);
    chk("initb_fall", fall_b, 2'b11);
    chk("model_pin_fall", m_out[1], 2'b00);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
